// File: rtl/am_pkg.sv
// Shared constants, types and state encoding for the associative-memory datapath.
// Both the AND array and the similarity accumulator import this so widths agree.
package am_pkg;

    localparam int NUM_CLASSES     = 26;
    localparam int DIMS_PER_CC     = 1024;
    localparam int SEQ_CYCLE_COUNT = 4;
    localparam int SCORE_W         = $clog2(DIMS_PER_CC * SEQ_CYCLE_COUNT + 1);
    localparam int IDX_W           = $clog2(NUM_CLASSES);
    localparam int PC_W            = $clog2(DIMS_PER_CC + 1);
    localparam int SEG_W           = $clog2(SEQ_CYCLE_COUNT);

    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } am_acc_state_e;

endpackage

// File: rtl/am_popcount.sv
// Balanced adder-tree popcount of one per-class AND vector segment.
// The input width must be a power of two; every tree level is a separate array.
module am_popcount
    import am_pkg::*;
#(
    parameter int W     = DIMS_PER_CC,
    parameter int OUT_W = PC_W
) (
    input  logic [W-1:0]     vec,
    output logic [OUT_W-1:0] count
);

    localparam int LEVELS = $clog2(W);

    // Level 1 pairs raw input bits; each later level pairs the sums of the one below.
    for (genvar l = 1; l <= LEVELS; l++) begin : lvl
        localparam int N = W >> l;
        logic [OUT_W-1:0] sum [N];
        for (genvar i = 0; i < N; i++) begin : node
            if (l == 1) begin : leaf
                assign sum[i] = OUT_W'(vec[2*i]) + OUT_W'(vec[2*i+1]);
            end else begin : inner
                assign sum[i] = lvl[l-1].sum[2*i] + lvl[l-1].sum[2*i+1];
            end
        end
    end

    assign count = lvl[LEVELS].sum[0];

endmodule

// File: rtl/am_similarity_accum.sv
// Accumulates per-class overlap scores over the segments of a query, then
// scans the classes one per cycle for the best match and offers the result.
module am_similarity_accum
    import am_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [SEG_W-1:0]                         query_ctr,
    input  logic [NUM_CLASSES-1:0][DIMS_PER_CC-1:0]  and_array_out,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [IDX_W-1:0]                         class_idx,
    output logic [SCORE_W-1:0]                       class_score,
    output logic                                     seq_err
);

    am_acc_state_e    state, state_next;
    score_t           acc [NUM_CLASSES];
    logic [PC_W-1:0]  pc  [NUM_CLASSES];
    logic [SEG_W-1:0] seg_cnt;
    logic [IDX_W-1:0] idx;
    score_t           best_score;
    logic [IDX_W-1:0] best_idx;
    logic             accept;
    logic             in_order;
    logic             last_seg;
    logic             take_best;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pc
        am_popcount #(.W(DIMS_PER_CC), .OUT_W(PC_W)) u_pc (
            .vec   (and_array_out[c]),
            .count (pc[c])
        );
    end

    assign in_ready  = (state == ACCUM) && nrst;
    assign accept    = in_valid && in_ready;
    assign in_order  = (query_ctr == seg_cnt);
    assign last_seg  = (seg_cnt == SEG_W'(SEQ_CYCLE_COUNT - 1));
    // Strict compare so a tie keeps the lowest index already held.
    assign take_best = (idx == '0) || (acc[idx] > best_score);

    assign out_valid   = (state == DONE);
    assign class_idx   = best_idx;
    assign class_score = best_score;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ACCUM:   if (accept && in_order && last_seg) state_next = SEARCH;
            SEARCH:  if (idx == IDX_W'(NUM_CLASSES - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // An out-of-order beat throws away the partial query, including segment 0 repeats.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
            seg_cnt    <= '0;
            idx        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            seq_err    <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        if (in_order) begin
                            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= acc[i] + score_t'(pc[i]);
                            seg_cnt <= seg_cnt + 1'b1;
                            if (last_seg) begin
                                idx        <= '0;
                                best_score <= '0;
                                best_idx   <= '0;
                            end
                        end else begin
                            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
                            seg_cnt <= '0;
                            seq_err <= 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (take_best) begin
                        best_score <= acc[idx];
                        best_idx   <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
                        seg_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
